// File: rtl/alu_pkg.sv
// alu_pkg: op codes, FSM states and op classification shared by the multi-cycle ALU
package alu_pkg;
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_SHL = 4'b0010;
    localparam logic [3:0] OP_SHR = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_NOT = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_NEG = 4'b1001;
    localparam logic [3:0] OP_DIV = 4'b1010;
    localparam logic [3:0] OP_MOD = 4'b1011;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;
    function automatic logic is_multi(input logic [3:0] op);
        return op == OP_MUL || op == OP_DIV || op == OP_MOD;
    endfunction
endpackage

// File: rtl/alu_mc_iter.sv
// alu_mc_iter: one-bit-per-step unsigned shift-add multiply / restoring divide on magnitudes
module alu_mc_iter import alu_pkg::*; #(
    parameter int WIDTH = 16,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic               mode,
    input  logic [WIDTH-1:0]   lo_init,
    input  logic [WIDTH-1:0]   m_init,
    output logic [CW-1:0]      count,
    output logic [2*WIDTH-1:0] res
);
    logic [WIDTH-1:0] hi, lo, m, hi_n, lo_n;
    logic [WIDTH:0]   sum, dif;
    // hi:lo is the product accumulator for multiply, remainder:quotient for divide
    always_comb begin
        sum  = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
        dif  = {hi, lo[WIDTH-1]} - {1'b0, m};
        hi_n = mode == MODE_DIV ? (dif[WIDTH] ? {hi[WIDTH-2:0], lo[WIDTH-1]} : dif[WIDTH-1:0]) : sum[WIDTH:1];
        lo_n = mode == MODE_DIV ? {lo[WIDTH-2:0], ~dif[WIDTH]} : {sum[0], lo[WIDTH-1:1]};
        res  = {hi_n, lo_n};
    end
    // load seeds the iteration, each step consumes one operand bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi    <= '0;
            lo    <= '0;
            m     <= '0;
            count <= '0;
        end else if (load) begin
            hi    <= '0;
            lo    <= lo_init;
            m     <= m_init;
            count <= CW'(WIDTH);
        end else if (step) begin
            hi    <= hi_n;
            lo    <= lo_n;
            count <= count - CW'(1);
        end
    end
endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle signed ALU with Start/Busy/Done handshake and registered result
module alu_mc import alu_pkg::*; #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUop,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] S,
    output logic             IsZero,
    output logic             OFL
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] WL = WIDTH'(WIDTH);
    logic [0:0]         state;
    logic [3:0]         op_r;
    logic               sa, sb, accept, multi, sc_o, mc_o, neg;
    logic [WIDTH-1:0]   mag_a, mag_b, sum, dif, sc_s, mc_s, quot, rem;
    logic [2*WIDTH-1:0] res, prod;
    logic [CW-1:0]      count;
    assign accept = Start && state == IDLE;
    assign multi  = is_multi(ALUop) && (ALUop == OP_MUL || B != '0);
    assign mag_a  = A[WIDTH-1] ? -A : A;
    assign mag_b  = B[WIDTH-1] ? -B : B;
    assign Busy   = state == RUN;
    assign IsZero = S == '0;
    alu_mc_iter #(.WIDTH(WIDTH)) u_iter (
        .clk     (CLK),
        .rst     (Reset),
        .load    (accept && multi),
        .step    (state == RUN),
        .mode    (op_r == OP_MUL ? MODE_MUL : MODE_DIV),
        .lo_init (ALUop == OP_MUL ? mag_b : mag_a),
        .m_init  (ALUop == OP_MUL ? mag_a : mag_b),
        .count   (count),
        .res     (res)
    );
    // single-cycle datapath; divide-by-zero lands here since it never enters RUN
    always_comb begin
        sum  = A + B;
        dif  = A - B;
        sc_s = '1;
        sc_o = 1'b0;
        case (ALUop)
            OP_ADD: begin
                sc_s = sum;
                sc_o = A[WIDTH-1] == B[WIDTH-1] && sum[WIDTH-1] != A[WIDTH-1];
            end
            OP_SUB: begin
                sc_s = dif;
                sc_o = A[WIDTH-1] != B[WIDTH-1] && dif[WIDTH-1] != A[WIDTH-1];
            end
            OP_SHL: sc_s = B < WL ? A << B : '0;
            OP_SHR: sc_s = B < WL ? A >> B : '0;
            OP_AND: sc_s = A & B;
            OP_OR:  sc_s = A | B;
            OP_XOR: sc_s = A ^ B;
            OP_NOT: sc_s = ~A;
            OP_NEG: begin
                sc_s = -A;
                sc_o = A == MIN;
            end
            OP_DIV, OP_MOD: sc_o = 1'b1;
            default: sc_o = 1'b0;
        endcase
    end
    // sign fix-up of the final iteration result using the signs latched at acceptance
    always_comb begin
        neg  = sa ^ sb;
        prod = neg ? -res : res;
        quot = neg ? -res[WIDTH-1:0] : res[WIDTH-1:0];
        rem  = sa ? -res[2*WIDTH-1:WIDTH] : res[2*WIDTH-1:WIDTH];
        mc_s = op_r == OP_MUL ? prod[WIDTH-1:0] : op_r == OP_DIV ? quot : rem;
        mc_o = op_r == OP_MUL ? !(&prod[2*WIDTH-1:WIDTH-1] || ~|prod[2*WIDTH-1:WIDTH-1]) :
               op_r == OP_DIV && !neg && res[WIDTH-1];
    end
    // control FSM and output registers; results hold until the next completion
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            op_r  <= OP_ADD;
            sa    <= 1'b0;
            sb    <= 1'b0;
            S     <= '0;
            OFL   <= 1'b0;
            Done  <= 1'b0;
        end else if (accept && multi) begin
            state <= RUN;
            op_r  <= ALUop;
            sa    <= A[WIDTH-1];
            sb    <= B[WIDTH-1];
            Done  <= 1'b0;
        end else if (accept) begin
            S     <= sc_s;
            OFL   <= sc_o;
            Done  <= 1'b1;
        end else if (state == RUN && count == CW'(1)) begin
            state <= IDLE;
            S     <= mc_s;
            OFL   <= mc_o;
            Done  <= 1'b1;
        end else begin
            Done  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: scoreboard bench for the multi-cycle ALU at WIDTH 16 plus a WIDTH 8 spot check
module tb_alu_mc;
    import alu_pkg::*;
    logic        CLK = 1'b0, Reset = 1'b1, Start = 1'b0;
    logic [15:0] A = '0, B = '0, S;
    logic [3:0]  ALUop = '0;
    logic        Busy, Done, IsZero, OFL;
    logic        start8 = 1'b0, busy8, done8, iszero8, ofl8;
    logic [7:0]  a8 = '0, b8 = '0, s8;
    logic [3:0]  op8 = '0;
    int total = 0, bad = 0, cyc = 0;
    typedef struct {
        logic [15:0] s;
        logic        ofl;
        int          lat;
        int          acc;
        string       name;
    } exp_t;
    exp_t sbq[$];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    alu_mc #(.WIDTH(16)) dut (
        .CLK(CLK), .Reset(Reset), .Start(Start), .A(A), .B(B), .ALUop(ALUop),
        .Busy(Busy), .Done(Done), .S(S), .IsZero(IsZero), .OFL(OFL)
    );
    alu_mc #(.WIDTH(8)) dut8 (
        .CLK(CLK), .Reset(Reset), .Start(start8), .A(a8), .B(b8), .ALUop(op8),
        .Busy(busy8), .Done(done8), .S(s8), .IsZero(iszero8), .OFL(ofl8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // issue one Start pulse (called at a negedge) and record the expected response
    task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] es, input logic eo, input int lat, input string name);
        Start = 1'b1;
        ALUop = op;
        A = a;
        B = b;
        sbq.push_back('{es, eo, lat, cyc + 1, name});
        @(negedge CLK);
        Start = 1'b0;
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (sbq.size() != 0 && k < 60) begin
            @(negedge CLK);
            k++;
        end
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got %0d pending want 0", name, sbq.size());
            sbq.delete();
        end
        @(negedge CLK);
    endtask

    // monitor: every Done must match the oldest outstanding expectation
    always @(negedge CLK) begin
        exp_t e;
        if (!Reset && Done) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got S=%0h want no Done", S);
            end else begin
                e = sbq.pop_front();
                chk({e.name, "_s"}, 32'(S), 32'(e.s));
                chk({e.name, "_ofl"}, 32'(OFL), 32'(e.ofl));
                chk({e.name, "_zero"}, 32'(IsZero), 32'(e.s == 16'h0));
                chk({e.name, "_lat"}, 32'(cyc - e.acc), 32'(e.lat));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        repeat (2) @(negedge CLK);
        chk("rst_s", 32'(S), 32'h0);
        chk("rst_zero", 32'(IsZero), 32'h1);
        chk("rst_ofl", 32'(OFL), 32'h0);
        chk("rst_done", 32'(Done), 32'h0);
        chk("rst_busy", 32'(Busy), 32'h0);
        Reset = 1'b0;
        @(negedge CLK);
        send(OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 0, "add_ofl");
        send(OP_SUB, 16'h0005, 16'h0005, 16'h0000, 1'b0, 0, "sub_zero");
        send(OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 0, "sub_ofl");
        send(OP_AND, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 0, "and");
        send(OP_OR,  16'hF0F0, 16'h0FF0, 16'hFFF0, 1'b0, 0, "or");
        send(OP_XOR, 16'hF0F0, 16'h0FF0, 16'hFF00, 1'b0, 0, "xor");
        send(OP_NOT, 16'h00FF, 16'h1234, 16'hFF00, 1'b0, 0, "not");
        send(OP_NEG, 16'h8000, 16'h0000, 16'h8000, 1'b1, 0, "neg_min");
        send(OP_NEG, 16'h0005, 16'h0000, 16'hFFFB, 1'b0, 0, "neg");
        send(OP_SHL, 16'h0001, 16'd15, 16'h8000, 1'b0, 0, "shl15");
        send(OP_SHR, 16'h8000, 16'd15, 16'h0001, 1'b0, 0, "shr15");
        send(OP_SHL, 16'h0001, 16'd16, 16'h0000, 1'b0, 0, "shl16");
        send(4'b1111, 16'h1234, 16'h5678, 16'hFFFF, 1'b0, 0, "undef");
        drain("single");
        repeat (3) @(negedge CLK);
        chk("hold_s", 32'(S), 32'hFFFF);
        chk("hold_done", 32'(Done), 32'h0);
        send(OP_DIV, 16'h0005, 16'h0000, 16'hFFFF, 1'b1, 0, "div0");
        drain("div0");
        send(OP_MUL, 16'hFFFD, 16'h0007, 16'hFFEB, 1'b0, 16, "mul_neg");
        for (int i = 0; i < 3; i++) begin
            Start = 1'b1;
            ALUop = OP_ADD;
            A = 16'(i);
            B = 16'h0100;
            @(negedge CLK);
            chk("busy_run", 32'(Busy), 32'h1);
            Start = 1'b0;
            @(negedge CLK);
        end
        drain("mul_neg");
        send(OP_MUL, 16'd300, 16'd300, 16'h5F90, 1'b1, 16, "mul_ofl");
        drain("mul_ofl");
        send(OP_DIV, 16'hFFF9, 16'h0002, 16'hFFFD, 1'b0, 16, "div_neg");
        drain("div_neg");
        send(OP_MOD, 16'hFFF9, 16'h0002, 16'hFFFF, 1'b0, 16, "mod_neg");
        drain("mod_neg");
        send(OP_DIV, 16'h8000, 16'hFFFF, 16'h8000, 1'b1, 16, "div_min");
        drain("div_min");
        send(OP_DIV, 16'h0007, 16'hFFFE, 16'hFFFD, 1'b0, 16, "div_negb");
        drain("div_negb");
        send(OP_MOD, 16'h0007, 16'hFFFE, 16'h0001, 1'b0, 16, "mod_negb");
        drain("mod_negb");
        send(OP_MUL, 16'h0002, 16'h0003, 16'h0006, 1'b0, 16, "b2b_mul");
        k = 0;
        while (!Done && k < 40) begin
            @(negedge CLK);
            k++;
        end
        send(OP_ADD, 16'h1234, 16'h0001, 16'h1235, 1'b0, 0, "b2b_add");
        drain("b2b");
        Start = 1'b1;
        ALUop = OP_MUL;
        A = 16'd100;
        B = 16'd200;
        @(negedge CLK);
        Start = 1'b0;
        repeat (5) @(negedge CLK);
        chk("mid_busy", 32'(Busy), 32'h1);
        Reset = 1'b1;
        #1;
        chk("abort_busy", 32'(Busy), 32'h0);
        chk("abort_done", 32'(Done), 32'h0);
        chk("abort_s", 32'(S), 32'h0);
        chk("abort_zero", 32'(IsZero), 32'h1);
        @(negedge CLK);
        Reset = 1'b0;
        @(negedge CLK);
        send(OP_ADD, 16'h0001, 16'h0001, 16'h0002, 1'b0, 0, "post_rst_add");
        drain("post_rst");
        start8 = 1'b1;
        op8 = OP_MUL;
        a8 = 8'd12;
        b8 = 8'd12;
        @(negedge CLK);
        start8 = 1'b0;
        k = 0;
        while (!done8 && k < 40) begin
            @(negedge CLK);
            k++;
        end
        chk("w8_lat", 32'(k), 32'd8);
        chk("w8_s", 32'(s8), 32'h90);
        chk("w8_ofl", 32'(ofl8), 32'h1);
        chk("w8_zero", 32'(iszero8), 32'h0);
        @(negedge CLK);
        chk("w8_busy", 32'(busy8), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
